// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage. Generates sequential word-aligned fetch addresses,
// issues them over a valid/ready request channel, and buffers the in-order
// memory responses together with their PC in a small FIFO that feeds decode
// over a valid/ready handshake. A redirect flushes the FIFO, restarts fetch
// at the new PC and marks every request still in flight as stale so that its
// response is dropped when it eventually returns.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   imem_req_valid    fetch request valid
//   imem_req_addr     fetch address (word aligned)
//   imem_req_ready    memory accepts the request
//   imem_rsp_valid    response valid (always accepted)
//   imem_rsp_data     instruction word
//   redirect_valid    one-cycle flush-and-refetch pulse
//   redirect_pc       new fetch address
//   if_valid          instruction available to decode
//   if_ready          decode accepts the instruction
//   if_inst, if_pc    instruction word at the FIFO head and its PC
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;

    logic [31:0]   fifo_pc_reg   [DEPTH];
    logic [31:0]   fifo_inst_reg [DEPTH];

    logic [CW:0]   occupancy;
    logic          req_fire;
    logic          pop;
    logic          rsp_drop_discard;
    logic          rsp_take;
    logic          push;

    // Issue is gated by registered occupancy only, so it never depends
    // combinationally on either ready input. rst_n gates it so the request
    // drops immediately when reset is asserted.
    assign occupancy      = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign imem_req_valid = rst_n && !redirect_valid && (occupancy < DEPTH_W);
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_valid = (count_reg != '0);
    assign if_inst  = fifo_inst_reg[head_reg];
    assign if_pc    = fifo_pc_reg[head_reg];
    assign pop      = if_valid && if_ready;

    // A response either retires a stale request (discard) or a live one
    // (outstanding); one arriving with neither pending is ignored.
    assign rsp_drop_discard = imem_rsp_valid && (discard_reg != '0);
    assign rsp_take         = imem_rsp_valid && (discard_reg == '0) && (outstanding_reg != '0);
    assign push             = rsp_take && !redirect_valid;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        count_next       = count_reg;
        head_next        = head_reg;
        tail_next        = tail_reg;

        if (redirect_valid) begin
            fetch_pc_next    = redirect_pc;
            rsp_pc_next      = redirect_pc;
            count_next       = '0;
            head_next        = '0;
            tail_next        = '0;
            outstanding_next = '0;
            // A live response landing this cycle is dropped and retires one
            // of the outstanding requests before the rest become stale.
            discard_next     = discard_reg - CW'(rsp_drop_discard)
                             + (outstanding_reg - CW'(rsp_take));
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (push) begin
                rsp_pc_next = rsp_pc_reg + 32'd4;
                tail_next   = tail_reg + PW'(1);
            end
            if (pop) begin
                head_next = head_reg + PW'(1);
            end
            outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_take);
            discard_next     = discard_reg - CW'(rsp_drop_discard);
            count_next       = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            count_reg       <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            count_reg       <= count_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
        end
    end

    // FIFO storage is cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_reg[i]   <= '0;
                fifo_inst_reg[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_reg[tail_reg]   <= rsp_pc_reg;
            fifo_inst_reg[tail_reg] <= imem_rsp_data;
        end
    end

endmodule
